// File: rtl/mips32_pkg.sv
// mips32_pkg: shared widths, requester ids and arbiter FSM encodings.
`default_nettype none

package mips32_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    REQ_IF  = 2'd0,
    REQ_MEM = 2'd1,
    REQ_DBG = 2'd2
  } req_id_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; last=1 means requester b was served last.
`default_nettype none

module rr_arb2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic grant_b
);

  assign grant_b = req_b & (~req_a | ~last);

endmodule

`default_nettype wire

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: three-requester arbiter for a single-port SRAM (dbg > if/mem round-robin).
// Rev 1.0
`default_nettype none

module mips_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic              mem_req,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic              mem_we,
  input  logic              dbg_we,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              if_ack,
  output logic              mem_ack,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  arb_state_e        state_q;
  req_id_e           id_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rr_last_q;
  logic              if_ack_q, mem_ack_q, dbg_ack_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q, dbg_rdata_q;
  logic              sram_en_q, sram_we_q;

  logic              if_elig, mem_elig, dbg_elig, any_elig, grant_mem;
  req_id_e           win_id_d;
  logic [ADDR_W-1:0] addr_d;
  logic              we_d;
  logic [DATA_W-1:0] wdata_d;

  // A requester being acked this cycle must not be re-granted on its stale req.
  assign if_elig  = if_req  & ~if_ack_q;
  assign mem_elig = mem_req & ~mem_ack_q;
  assign dbg_elig = dbg_req & ~dbg_ack_q;
  assign any_elig = if_elig | mem_elig | dbg_elig;

  rr_arb2 u_rr (
    .req_a   (if_elig),
    .req_b   (mem_elig),
    .last    (rr_last_q),
    .grant_b (grant_mem)
  );

  always_comb begin
    win_id_d = REQ_IF;
    addr_d   = if_addr;
    we_d     = 1'b0;
    wdata_d  = '0;
    if (dbg_elig) begin
      win_id_d = REQ_DBG;
      addr_d   = dbg_addr;
      we_d     = dbg_we;
      wdata_d  = dbg_wdata;
    end else if (grant_mem) begin
      win_id_d = REQ_MEM;
      addr_d   = mem_addr;
      we_d     = mem_we;
      wdata_d  = mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      id_q        <= REQ_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rr_last_q   <= 1'b1;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      dbg_rdata_q <= '0;
      sram_en_q   <= 1'b0;
      sram_we_q   <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_elig) begin
            id_q      <= win_id_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            sram_en_q <= 1'b1;
            sram_we_q <= we_d;
            state_q   <= ST_ACCESS;
            if (win_id_d != REQ_DBG) rr_last_q <= (win_id_d == REQ_MEM);
          end
        end
        ST_ACCESS: begin
          sram_en_q <= 1'b0;
          sram_we_q <= 1'b0;
          state_q   <= ST_RESP;
        end
        ST_RESP: begin
          case (id_q)
            REQ_IF:  begin if_ack_q  <= 1'b1; if (!we_q) if_rdata_q  <= sram_rdata; end
            REQ_MEM: begin mem_ack_q <= 1'b1; if (!we_q) mem_rdata_q <= sram_rdata; end
            default: begin dbg_ack_q <= 1'b1; if (!we_q) dbg_rdata_q <= sram_rdata; end
          endcase
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_ack     = if_ack_q;
  assign mem_ack    = mem_ack_q;
  assign dbg_ack    = dbg_ack_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: scoreboard bench with an SRAM model for mips_mem_arbiter.
`default_nettype none

module tb_mips_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam logic [1:0] ID_IF = 2'd0, ID_MEM = 2'd1, ID_DBG = 2'd2;

  typedef struct {
    logic [1:0]    id;
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 0, mem_req = 0, dbg_req = 0;
  logic [AW-1:0] if_addr = '0, mem_addr = '0, dbg_addr = '0;
  logic          mem_we = 0, dbg_we = 0;
  logic [DW-1:0] mem_wdata = '0, dbg_wdata = '0;
  logic          if_ack, mem_ack, dbg_ack;
  logic [DW-1:0] if_rdata, mem_rdata, dbg_rdata;
  logic          sram_en, sram_we, busy;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  exp_t          sb[$];
  exp_t          mon_e;
  int            mon_n;
  logic [1:0]    mon_id;
  logic [DW-1:0] mon_data;
  int            chk_cnt = 0;
  int            pass_cnt = 0;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .mem_req(mem_req), .dbg_req(dbg_req),
    .if_addr(if_addr), .mem_addr(mem_addr), .dbg_addr(dbg_addr),
    .mem_we(mem_we), .dbg_we(dbg_we),
    .mem_wdata(mem_wdata), .dbg_wdata(dbg_wdata),
    .if_ack(if_ack), .mem_ack(mem_ack), .dbg_ack(dbg_ack),
    .if_rdata(if_rdata), .mem_rdata(mem_rdata), .dbg_rdata(dbg_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
  );

  // Single-port SRAM: read data appears the cycle after sram_en.
  always @(posedge clk) begin
    if (sram_en === 1'b1) begin
      if (sram_we === 1'b1) sram_mem[sram_addr] <= sram_wdata;
      else                  sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Every ack must match the head of the scoreboard in requester and read data.
  always @(negedge clk) begin
    mon_n = int'(if_ack === 1'b1) + int'(mem_ack === 1'b1) + int'(dbg_ack === 1'b1);
    if (mon_n != 0) begin
      chk_cnt++;
      if (mon_n != 1 || sb.size() == 0) begin
        $display("FAIL sb_ack: acks if/mem/dbg=%b%b%b, queued expectations=%0d (need exactly one ack and one entry)",
                 if_ack, mem_ack, dbg_ack, sb.size());
      end else begin
        mon_e    = sb.pop_front();
        mon_id   = if_ack ? ID_IF : (mem_ack ? ID_MEM : ID_DBG);
        mon_data = if_ack ? if_rdata : (mem_ack ? mem_rdata : dbg_rdata);
        if (mon_id !== mon_e.id || (mon_e.rd && mon_data !== mon_e.data))
          $display("FAIL sb_ack: got id=%0d data=%h, expected id=%0d data=%h (rd=%0d)",
                   mon_id, mon_data, mon_e.id, mon_e.data, mon_e.rd);
        else
          pass_cnt++;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic rd, input logic [DW-1:0] data);
    exp_t e;
    e.id = id; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    chk_cnt++;
    if ({busy, sram_en, sram_we, if_ack, mem_ack, dbg_ack} !== 6'b0)
      $display("FAIL reset_ctrl: busy/en/we/acks=%b, expected 000000",
               {busy, sram_en, sram_we, if_ack, mem_ack, dbg_ack});
    else pass_cnt++;
    chk_cnt++;
    if ({if_rdata, mem_rdata, dbg_rdata, sram_addr, sram_wdata} !== '0)
      $display("FAIL reset_data: rdata/addr/wdata not zero (%h %h %h %h %h)",
               if_rdata, mem_rdata, dbg_rdata, sram_addr, sram_wdata);
    else pass_cnt++;
  endtask

  task automatic test_if_read;
    if_req = 1'b1; if_addr = 10'd5;
    push(ID_IF, 1'b1, 32'h00222000);
    step();
    chk_cnt++;
    if ({sram_en, sram_we, busy} !== 3'b101 || sram_addr !== 10'd5)
      $display("FAIL if_read_access: en/we/busy=%b addr=%0d, expected 101 addr=5",
               {sram_en, sram_we, busy}, sram_addr);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (if_ack !== 1'b0 || sram_en !== 1'b0)
      $display("FAIL if_read_resp: ack=%b en=%b, expected 0 0", if_ack, sram_en);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (if_ack !== 1'b1) $display("FAIL if_read_latency: if_ack=%b at C+3, expected 1", if_ack);
    else pass_cnt++;
    if_req = 1'b0;
    step();
    chk_cnt++;
    if (busy !== 1'b0 || if_rdata !== 32'h00222000)
      $display("FAIL if_read_idle: busy=%b rdata=%h, expected 0 00222000", busy, if_rdata);
    else pass_cnt++;
  endtask

  task automatic test_write_read;
    int n;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 10'd20; mem_wdata = 32'hDEADBEEF;
    push(ID_MEM, 1'b0, '0);
    n = 0;
    do begin step(); n++; end while (mem_ack !== 1'b1 && n < 10);
    chk_cnt++;
    if (mem_ack !== 1'b1 || n != 3) $display("FAIL mem_write_ack: ack=%b after %0d cycles, expected 1 after 3", mem_ack, n);
    else pass_cnt++;
    mem_we = 1'b0; mem_wdata = '0;
    push(ID_MEM, 1'b1, 32'hDEADBEEF);
    n = 0;
    do begin step(); n++; end while (mem_ack !== 1'b1 && n < 10);
    chk_cnt++;
    if (mem_ack !== 1'b1 || mem_rdata !== 32'hDEADBEEF)
      $display("FAIL mem_read_back: ack=%b rdata=%h, expected 1 DEADBEEF", mem_ack, mem_rdata);
    else pass_cnt++;
    mem_req = 1'b0;
    step();
  endtask

  task automatic test_round_robin;
    logic [1:0] got, exp_ack;
    do_reset();
    if_req = 1'b1; if_addr = 10'd7;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'd8;
    push(ID_IF, 1'b1, 32'h10000007);
    push(ID_MEM, 1'b1, 32'h10000008);
    push(ID_IF, 1'b1, 32'h10000007);
    push(ID_MEM, 1'b1, 32'h10000008);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      got = {if_ack, mem_ack};
      exp_ack = (cyc % 3 != 0) ? 2'b00 : (((cyc / 3) % 2 == 1) ? 2'b10 : 2'b01);
      if (cyc % 3 == 0) begin
        chk_cnt++;
        if (got !== exp_ack) $display("FAIL rr_grant_%0d: if/mem ack=%b, expected %b", cyc, got, exp_ack);
        else pass_cnt++;
      end else if (got !== 2'b00) begin
        chk_cnt++;
        $display("FAIL rr_gap_%0d: if/mem ack=%b, expected 00", cyc, got);
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    step(); step(); step();
    chk_cnt++;
    if (busy !== 1'b0 || sb.size() != 0) $display("FAIL rr_drain: busy=%b queued=%0d, expected 0 0", busy, sb.size());
    else pass_cnt++;
  endtask

  task automatic test_dbg_priority;
    logic [2:0] got;
    do_reset();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'd100; dbg_wdata = 32'hCAFE0001;
    if_req = 1'b1; if_addr = 10'd100;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'd5;
    push(ID_DBG, 1'b0, '0);
    push(ID_IF, 1'b1, 32'hCAFE0001);
    push(ID_MEM, 1'b1, 32'h00222000);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      got = {dbg_ack, if_ack, mem_ack};
      if (cyc == 3 || cyc == 6 || cyc == 9) begin
        chk_cnt++;
        if (got !== (cyc == 3 ? 3'b100 : (cyc == 6 ? 3'b010 : 3'b001)))
          $display("FAIL dbg_order_%0d: dbg/if/mem ack=%b", cyc, got);
        else pass_cnt++;
      end
      if (dbg_ack === 1'b1) begin dbg_req = 1'b0; dbg_we = 1'b0; end
      if (if_ack === 1'b1) if_req = 1'b0;
      if (mem_ack === 1'b1) mem_req = 1'b0;
    end
    chk_cnt++;
    if (dbg_rdata !== '0) $display("FAIL dbg_write_rdata: dbg_rdata=%h, expected 00000000", dbg_rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort;
    int n;
    if_req = 1'b1; if_addr = 10'd5;
    step();
    step();
    rst = 1'b1;
    step();
    chk_cnt++;
    if (if_ack !== 1'b0 || if_rdata !== '0 || busy !== 1'b0)
      $display("FAIL abort_state: ack=%b rdata=%h busy=%b, expected 0 00000000 0", if_ack, if_rdata, busy);
    else pass_cnt++;
    rst = 1'b0;
    push(ID_IF, 1'b1, 32'h00222000);
    n = 0;
    do begin step(); n++; end while (if_ack !== 1'b1 && n < 10);
    chk_cnt++;
    if (if_ack !== 1'b1 || n != 3 || if_rdata !== 32'h00222000)
      $display("FAIL abort_retry: ack=%b after %0d cycles rdata=%h, expected 1 after 3 00222000", if_ack, n, if_rdata);
    else pass_cnt++;
    if_req = 1'b0;
    step();
  endtask

  task automatic test_pulse_ignored;
    int mem_hits, mem_acks, if_acks;
    mem_hits = 0; mem_acks = 0; if_acks = 0;
    if_req = 1'b1; if_addr = 10'd6;
    push(ID_IF, 1'b1, 32'h10000006);
    step();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 10'd33;
    step();
    mem_req = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (sram_en === 1'b1 && sram_addr === 10'd33) mem_hits++;
      if (mem_ack === 1'b1) mem_acks++;
      if (if_ack === 1'b1) begin if_acks++; if_req = 1'b0; end
      step();
    end
    chk_cnt++;
    if (mem_hits != 0 || mem_acks != 0 || if_acks != 1)
      $display("FAIL pulse_ignored: mem sram hits=%0d mem acks=%0d if acks=%0d, expected 0 0 1",
               mem_hits, mem_acks, if_acks);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 32'h10000000 + i;
    sram_mem[5] = 32'h00222000;
    test_reset();
    test_if_read();
    test_write_read();
    test_round_robin();
    test_dbg_priority();
    test_reset_abort();
    test_pulse_ignored();
    step();
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL sb_empty: %0d expected acks never seen", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
